// File: rtl/async_cnt_pkg.sv
// ============================================================================
// Module : async_cnt_pkg
// Brief  : Shared FSM state type and default widths for the ripple-count reader
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package async_cnt_pkg;

    localparam int c_cnt_w_def       = 4;
    localparam int c_ext_w_def       = 16;
    localparam int c_sync_stages_def = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_PRESENT = 2'd2
    } rd_state_t;

endpackage

`default_nettype wire

// File: rtl/async_count_reader_if.sv
// ============================================================================
// Module : async_count_reader_if
// Brief  : Counter input, control and snapshot handshake bundle
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface async_count_reader_if
    import async_cnt_pkg::*;
#(
    parameter int CNT_W = c_cnt_w_def,
    parameter int EXT_W = c_ext_w_def
);

    logic [CNT_W-1:0] cnt_in;
    logic             clr;
    logic             rd_req;
    logic             out_ready;
    logic             out_valid;
    logic [EXT_W-1:0] out_count;
    logic             overflow;
    logic             busy;

    // master: system-side consumer; slave: the reader itself
    modport master (
        output cnt_in, clr, rd_req, out_ready,
        input  out_valid, out_count, overflow, busy
    );

    modport slave (
        input  cnt_in, clr, rd_req, out_ready,
        output out_valid, out_count, overflow, busy
    );

endinterface

`default_nettype wire

// File: rtl/cnt_sync_filter.sv
// ============================================================================
// Module : cnt_sync_filter
// Brief  : Synchronizer chain plus two-equal-sample stability filter
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnt_sync_filter
    import async_cnt_pkg::*;
#(
    parameter int CNT_W       = c_cnt_w_def,
    parameter int SYNC_STAGES = c_sync_stages_def
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic [CNT_W-1:0] cnt_in,
    output logic      [CNT_W-1:0] s_cur,
    output logic                  accept
);

    localparam int c_fill_max = SYNC_STAGES + 1;
    localparam int c_fill_w   = $clog2(c_fill_max + 1);

    logic [SYNC_STAGES-1:0][CNT_W-1:0] r_sync;
    logic [CNT_W-1:0]                  r_prev;
    logic [c_fill_w-1:0]               r_fill;

    // r_fill keeps reset-cleared flop contents from posing as a real stable pair
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
            r_prev <= '0;
            r_fill <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], cnt_in};
            r_prev <= r_sync[SYNC_STAGES-1];
            if (r_fill != c_fill_w'(c_fill_max)) begin
                r_fill <= r_fill + 1'b1;
            end
        end
    end

    assign s_cur  = r_sync[SYNC_STAGES-1];
    assign accept = (r_fill == c_fill_w'(c_fill_max)) && (s_cur == r_prev);

endmodule

`default_nettype wire

// File: rtl/async_count_reader.sv
// ============================================================================
// Module : async_count_reader
// Brief  : Wrap-aware extension of a ripple counter with handshake snapshots
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module async_count_reader
    import async_cnt_pkg::*;
#(
    parameter int CNT_W       = c_cnt_w_def,
    parameter int EXT_W       = c_ext_w_def,
    parameter int SYNC_STAGES = c_sync_stages_def
) (
    input  wire logic             clk,
    input  wire logic             reset,
    async_count_reader_if.slave   bus
);

    localparam int c_sum_w = EXT_W + 1;

    logic [CNT_W-1:0]   w_s_cur;
    logic               w_accept;
    logic [CNT_W-1:0]   w_delta;
    logic [c_sum_w-1:0] w_sum;
    logic               w_add;
    logic               w_snap;
    logic [EXT_W-1:0]   w_acc_next;

    logic [CNT_W-1:0]   r_base;
    logic               r_primed;
    logic [EXT_W-1:0]   r_acc;
    logic               r_overflow;

    rd_state_t          r_state;
    logic               r_out_valid;
    logic               r_busy;
    logic [EXT_W-1:0]   r_out_count;

    cnt_sync_filter #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_filter (
        .clk    (clk),
        .reset  (reset),
        .cnt_in (bus.cnt_in),
        .s_cur  (w_s_cur),
        .accept (w_accept)
    );

    // Modular subtraction makes a counter wrap look like an ordinary forward step
    assign w_delta = w_s_cur - r_base;

    always_comb begin
        w_sum      = {1'b0, r_acc} + c_sum_w'(w_delta);
        w_add      = w_accept && r_primed && !bus.clr;
        w_snap     = w_accept && !bus.clr;
        w_acc_next = w_add ? w_sum[EXT_W-1:0] : r_acc;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_base     <= '0;
            r_primed   <= 1'b0;
            r_acc      <= '0;
            r_overflow <= 1'b0;
        end else if (bus.clr) begin
            r_primed   <= 1'b0;
            r_acc      <= '0;
            r_overflow <= 1'b0;
        end else if (w_accept) begin
            r_base   <= w_s_cur;
            r_primed <= 1'b1;
            if (r_primed) begin
                r_acc <= w_sum[EXT_W-1:0];
                if (w_sum[EXT_W]) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    // A baseline-only accept also completes a capture, so a clear mid-capture yields 0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_out_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.rd_req) begin
                        r_state <= ST_CAPTURE;
                        r_busy  <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    if (w_snap) begin
                        r_out_count <= w_acc_next;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_count = r_out_count;
    assign bus.overflow  = r_overflow;
    assign bus.busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_async_count_reader.sv
// ============================================================================
// Module : tb_async_count_reader
// Brief  : Directed + random bench; expectations come from a true event-count model
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_async_count_reader;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    async_count_reader_if #(.CNT_W(4), .EXT_W(16)) bus ();

    async_count_reader #(
        .CNT_W       (4),
        .EXT_W       (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          errors  = 0;
    int          checks  = 0;
    int unsigned events  = 0;   // true number of events emitted by the source
    int unsigned base_ev = 0;   // event count at the most recent rebaseline

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] exp_acc();
        return 16'(events - base_ev);
    endfunction

    function automatic logic exp_ovf();
        return (events - base_ev) >= 32'd65536;
    endfunction

    task automatic set_cnt(input int unsigned ev, input int hold);
        events     = ev;
        bus.cnt_in = 4'(ev);
        cycles(hold);
    endtask

    task automatic advance(input int unsigned n);
        int unsigned left;
        int unsigned s;
        left = n;
        while (left > 0) begin
            s = $urandom_range(1, 15);
            if (s > left) s = left;
            set_cnt(events + s, 3);
            left -= s;
        end
    endtask

    task automatic request(input string tag);
        bus.rd_req = 1'b1;
        cycles(1);
        bus.rd_req = 1'b0;
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        int waited;
        waited = 0;
        while (!bus.out_valid && waited < 40) begin
            cycles(1);
            waited++;
        end
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    endtask

    task automatic transfer(input string tag);
        bus.out_ready = 1'b1;
        cycles(1);
        bus.out_ready = 1'b0;
        check({tag, "_vdrop"}, 32'(bus.out_valid), 32'd0);
    endtask

    // Full read of a settled counter; out_ready held low for `hold` cycles first
    task automatic snapshot(input string tag, input int hold);
        logic [15:0] e;
        logic        eo;
        e  = exp_acc();
        eo = exp_ovf();
        request(tag);
        wait_valid(tag);
        check({tag, "_count"}, 32'(bus.out_count), 32'(e));
        check({tag, "_ovf"}, 32'(bus.overflow), 32'(eo));
        for (int i = 0; i < hold; i++) begin
            cycles(1);
            check({tag, "_hold"}, {15'd0, bus.out_valid, bus.out_count}, {15'd0, 1'b1, e});
        end
        transfer(tag);
    endtask

    initial begin
        logic [15:0] frozen;
        int unsigned target;

        bus.cnt_in    = '0;
        bus.clr       = 1'b0;
        bus.rd_req    = 1'b0;
        bus.out_ready = 1'b0;

        cycles(3);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_count", 32'(bus.out_count), 32'd0);
        check("rst_ovf",   32'(bus.overflow),  32'd0);
        check("rst_busy",  32'(bus.busy),      32'd0);
        @(negedge clk) reset = 1'b1;
        cycles(6);

        // first count, valid must hold while consumer stalls
        set_cnt(5, 3);
        cycles(4);
        snapshot("first", 3);

        // wrap of the 4-bit source: 14 -> 15 -> 0 -> 3
        set_cnt(14, 3);
        set_cnt(15, 3);
        set_cnt(16, 3);
        set_cnt(19, 3);
        cycles(4);
        snapshot("wrap", 0);

        // one-cycle glitch to 7 between 2 and 3
        set_cnt(34, 3);
        bus.cnt_in = 4'd7;
        cycles(1);
        set_cnt(35, 3);
        cycles(4);
        snapshot("glitch", 0);

        for (int k = 0; k < 4; k++) begin
            advance($urandom_range(1, 80));
            cycles(4);
            snapshot("rand", 0);
        end

        // stall in PRESENT: extra request dropped, clr leaves snapshot alone
        request("stall");
        wait_valid("stall");
        frozen = exp_acc();
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin
                events     = events + 3;
                bus.cnt_in = 4'(events);
            end
            bus.rd_req = (i == 1);
            bus.clr    = (i == 4);
            cycles(1);
            bus.rd_req = 1'b0;
            bus.clr    = 1'b0;
            check("stall_count", 32'(bus.out_count), 32'(frozen));
            check("stall_state", {30'd0, bus.busy, bus.out_valid}, 32'd3);
        end
        base_ev = events;
        transfer("stall");
        cycles(3);
        check("stall_dropped", 32'(bus.busy), 32'd0);
        cycles(4);
        snapshot("postclr", 0);

        // overflow boundary
        target = base_ev + 32'd65534;
        advance(target - events);
        cycles(4);
        snapshot("near_max", 0);
        advance(4);
        cycles(4);
        snapshot("ovf", 0);
        bus.clr = 1'b1;
        cycles(1);
        bus.clr = 1'b0;
        base_ev = events;
        check("clr_ovf", 32'(bus.overflow), 32'd0);
        cycles(6);
        snapshot("rebase", 0);
        advance(3);
        cycles(4);
        snapshot("after_rebase", 0);

        // clr while capturing: snapshot comes from the baseline cycle
        advance(5);
        cycles(4);
        request("capclr");
        bus.clr = 1'b1;
        cycles(1);
        bus.clr = 1'b0;
        base_ev = events;
        wait_valid("capclr");
        check("capclr_count", 32'(bus.out_count), 32'd0);
        transfer("capclr");

        // reset pulled low mid-handshake
        advance(6);
        cycles(4);
        request("arst");
        wait_valid("arst");
        #2;
        reset = 1'b0;
        #1;
        check("arst_valid", 32'(bus.out_valid), 32'd0);
        check("arst_busy",  32'(bus.busy),      32'd0);
        check("arst_count", 32'(bus.out_count), 32'd0);
        cycles(2);
        @(negedge clk) reset = 1'b1;
        base_ev = events;
        cycles(8);
        snapshot("arst_base", 0);
        advance(2);
        cycles(4);
        snapshot("arst_add", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/async_count_reader.md
# async_count_reader

Reader for the 4-bit asynchronous (ripple) event counter. It samples the counter's free-running, glitch-prone output into the `clk` domain and filters out ripple transients. It extends the count into a wide accumulator that is modulo-aware across counter wrap. On request, it presents a snapshot over a valid/ready handshake to the system-side consumer.

## Interface
- `CNT_W`, 4: width of the ripple counter output being read.
- `EXT_W`, 16: width of the extended accumulator and snapshot.
- `SYNC_STAGES`, 2: flop stages on `cnt_in` before filtering (minimum 2).

Ports:
- `clk` in 1: single system clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-low; all state cleared while low.
- `cnt_in` in CNT_W: raw ripple counter output, asynchronous to `clk`.
- `clr` in 1: synchronous clear of accumulator and overflow flag, with rebaseline.
- `rd_req` in 1: single-cycle snapshot request.
- `out_valid` out 1: snapshot available.
- `out_ready` in 1: consumer accepts snapshot.
- `out_count` out EXT_W: snapshot value, stable while `out_valid`.
- `overflow` out 1: sticky; accumulator wrapped past 2^EXT_W-1.
- `busy` out 1: request in progress (state != IDLE).

## Operation
- Synchronizer: `cnt_in` passes through SYNC_STAGES flops to produce `s_cur`.
- Stability filter: a sample is accepted when `s_cur` equals its previous-cycle value (two consecutive equal samples). Unequal pairs are discarded.
- Baseline: the first accepted sample after reset or `clr` loads `base` only; nothing is added (`primed` set).
- Accumulate: on each later accepted sample, `delta = (s_cur - base) mod 2^CNT_W` (CNT_W-bit unsigned). Then `acc += delta` in EXT_W bits with wrap, and `base = s_cur`.
  - Carry out of `acc` sets `overflow`, which stays set until `clr` or reset.
  - The source must not advance 2^CNT_W or more events between accepted samples. Such aliasing is undetectable and out of scope.
- `clr` zeroes `acc`, clears `overflow` and `primed`, and discards any same-cycle delta (`clr` wins).
- FSM states:
  - IDLE: on `rd_req`, go to CAPTURE.
  - CAPTURE: wait for the next accumulate update, or the next accepted sample if delta is 0. Then copy the post-update `acc` into `out_count` and go to PRESENT.
  - PRESENT: `out_valid`=1. On `out_ready`, go to IDLE.
- `rd_req` in CAPTURE or PRESENT is ignored (not queued).
- Accumulation continues in every state. `out_count` is a frozen snapshot and does not track `acc`.
- `clr` in CAPTURE:
  - Snapshot is taken from the post-clear baseline cycle.
  - `out_count` = 0.
- `clr` in PRESENT leaves `out_count` and `out_valid` unchanged.
- Reset values: `out_valid`=0, `out_count`=0, `overflow`=0, `busy`=0, state IDLE, `acc`=0, `primed`=0.

## Timing
- `cnt_in` stable change to accepted sample: SYNC_STAGES+1 cycles. `acc` is updated 1 cycle later, so the total is SYNC_STAGES+2 cycles (4 at default).
- `rd_req` to `out_valid`: 2 cycles minimum, when an accept coincides with CAPTURE entry. Otherwise it is bounded by the next stable sample.
- Handshake:
  - Transfer occurs on the cycle with `out_valid` and `out_ready` both high.
  - `out_valid` drops the next cycle.
  - `out_ready` while `out_valid`=0 has no effect.
- Back-to-back: a new `rd_req` is accepted the cycle after the transfer.
- Reset low mid-handshake: `out_valid` drops immediately (asynchronous). No transfer is implied.

## Structure
- Shared package `async_cnt_pkg`: FSM state enum (IDLE, CAPTURE, PRESENT) and default width constants, shared with the counter-side blocks.
- One sub-module, `cnt_sync_filter`: the synchronizer chain plus stability filter. It outputs `s_cur` and an `accept` pulse.
- The accumulator and FSM live in the top module.

## Test plan
- Reset, then `cnt_in`=0→5 stable, then `rd_req` → `out_count`=5, `out_valid` held until `out_ready`.
- Count 14→15→0→3 (wrap at 2^CNT_W) → `acc` increases by 5 across the wrap; snapshot = prior value + 5.
- Inject a 1-cycle glitch value (7 between 2 and 3) → glitch is not accepted; `acc` steps by exactly 1.
- Preload `acc` near 16'hFFFE, then +4 events → `acc`=2, `overflow`=1; `clr` → `acc`=0, `overflow`=0. The next sample only rebaselines.
- `rd_req` while in PRESENT with `out_ready` low for 5 cycles → `out_count` unchanged, second request dropped, `busy`=1 throughout.
- `reset` pulled low during PRESENT → `out_valid`=0 immediately; after release, the first accepted sample adds 0.
